// File: rtl/s_term_pkg.sv
// Shared types and constants for the south-termination loopback tile.
package s_term_pkg;

   localparam int unsigned NUM_GRP = 4;
   localparam int unsigned CFG_W   = 2 * NUM_GRP;
   localparam int unsigned LFSR_W  = 16;

   // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
   localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;

   typedef enum logic [1:0] {
      MODE_BYPASS = 2'b00,
      MODE_REG    = 2'b01,
      MODE_PRBS   = 2'b10,
      MODE_TIE0   = 2'b11
   } mode_e;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], ^(s & LFSR_POLY)};
   endfunction

endpackage

// File: rtl/s_term_loopback_cfg_grp_mux.sv
// Per-group output selector: bypass reflection, registered reflection, PRBS or zero.
module s_term_grp_mux
   import s_term_pkg::*;
#(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0]      refl,
   input  logic [W-1:0]      refl_q,
   input  logic [LFSR_W-1:0] lfsr,
   input  mode_e             mode,
   output logic [W-1:0]      grp_c
);

   logic [W-1:0] prbs_c;
   logic         lfsr_unused_c;

   // PRBS bit i comes from lfsr[i mod 16]; narrow groups leave upper bits idle
   for (genvar i = 0; i < W; i++) begin : g_prbs
      assign prbs_c[i] = lfsr[i % LFSR_W];
   end
   assign lfsr_unused_c = ^lfsr;

   always_comb begin
      grp_c = '0;
      case (mode)
         MODE_BYPASS: grp_c = refl;
         MODE_REG:    grp_c = refl_q;
         MODE_PRBS:   grp_c = prbs_c;
         MODE_TIE0:   grp_c = '0;
         default:     grp_c = '0;
      endcase
   end

endmodule

// File: rtl/s_term_loopback_cfg.sv
// South-termination loopback with per-group runtime modes loaded over a serial chain.
// Optional S_TERM_ACTIVITY_CNT_EN adds a saturating input-activity counter act_count.
module s_term_loopback_cfg
   import s_term_pkg::*;
#(
   parameter int unsigned       W1        = 4,
   parameter int unsigned       W2        = 8,
   parameter int unsigned       W4        = 16,
   parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
   input  logic          UserCLK,
   input  logic          UserRST,
   input  logic [W1-1:0] S1END,
   input  logic [W2-1:0] S2MID,
   input  logic [W2-1:0] S2END,
   input  logic [W4-1:0] S4END,
   output logic [W1-1:0] N1BEG,
   output logic [W2-1:0] N2BEG,
   output logic [W2-1:0] N2BEGb,
   output logic [W4-1:0] N4BEG,
   input  logic          cfg_shift_en,
   input  logic          cfg_din,
   input  logic          cfg_update,
   output logic          cfg_dout
`ifdef S_TERM_ACTIVITY_CNT_EN
   ,
   output logic [15:0]   act_count
`endif
);

   logic [W1-1:0]     refl1_c,  refl1_q;
   logic [W2-1:0]     refl2_c,  refl2_q;
   logic [W2-1:0]     refl2b_c, refl2b_q;
   logic [W4-1:0]     refl4_c,  refl4_q;
   logic [CFG_W-1:0]  cfg_sr, mode_q;
   logic [LFSR_W-1:0] lfsr;
   mode_e             grp_mode [NUM_GRP];
   logic [NUM_GRP-1:0] is_prbs_c;
   logic              prbs_any_c;

   // Bit-order reversal within each group
   for (genvar i = 0; i < W1; i++) begin : g_r1
      assign refl1_c[i] = S1END[W1-1-i];
   end
   for (genvar i = 0; i < W2; i++) begin : g_r2
      assign refl2_c[i]  = S2MID[W2-1-i];
      assign refl2b_c[i] = S2END[W2-1-i];
   end
   for (genvar i = 0; i < W4; i++) begin : g_r4
      assign refl4_c[i] = S4END[W4-1-i];
   end

   for (genvar g = 0; g < NUM_GRP; g++) begin : g_mode
      assign grp_mode[g]  = mode_e'(mode_q[2*g +: 2]);
      assign is_prbs_c[g] = (grp_mode[g] == MODE_PRBS);
   end
   assign prbs_any_c = |is_prbs_c;

   // Config chain, active modes, LFSR and reflection pipeline
   always_ff @(posedge UserCLK or posedge UserRST) begin
      if (UserRST) begin
         cfg_sr   <= '0;
         mode_q   <= '0;
         lfsr     <= LFSR_SEED;
         refl1_q  <= '0;
         refl2_q  <= '0;
         refl2b_q <= '0;
         refl4_q  <= '0;
      end else begin
         if (cfg_shift_en) cfg_sr <= {cfg_din, cfg_sr[CFG_W-1:1]};
         if (cfg_update)   mode_q <= cfg_sr;
         if (prbs_any_c)   lfsr   <= lfsr_next(lfsr);
         refl1_q  <= refl1_c;
         refl2_q  <= refl2_c;
         refl2b_q <= refl2b_c;
         refl4_q  <= refl4_c;
      end
   end

   assign cfg_dout = cfg_sr[0];

   s_term_grp_mux #(.W(W1)) u_grp0 (
      .refl(refl1_c), .refl_q(refl1_q), .lfsr(lfsr), .mode(grp_mode[0]), .grp_c(N1BEG)
   );
   s_term_grp_mux #(.W(W2)) u_grp1 (
      .refl(refl2_c), .refl_q(refl2_q), .lfsr(lfsr), .mode(grp_mode[1]), .grp_c(N2BEG)
   );
   s_term_grp_mux #(.W(W2)) u_grp2 (
      .refl(refl2b_c), .refl_q(refl2b_q), .lfsr(lfsr), .mode(grp_mode[2]), .grp_c(N2BEGb)
   );
   s_term_grp_mux #(.W(W4)) u_grp3 (
      .refl(refl4_c), .refl_q(refl4_q), .lfsr(lfsr), .mode(grp_mode[3]), .grp_c(N4BEG)
   );

`ifdef S_TERM_ACTIVITY_CNT_EN
   logic act_chg_c;

   // Reflection is a bijection, so comparing against the pipeline detects any S toggle
   assign act_chg_c = ({refl1_c, refl2_c, refl2b_c, refl4_c} !=
                       {refl1_q, refl2_q, refl2b_q, refl4_q});

   always_ff @(posedge UserCLK or posedge UserRST) begin
      if (UserRST) begin
         act_count <= '0;
      end else if (cfg_update) begin
         act_count <= '0;
      end else if (act_chg_c && (act_count != 16'hFFFF)) begin
         act_count <= act_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_s_term_loopback_cfg.sv
// Randomised bench for s_term_loopback_cfg with a behavioural model and per-cycle compare.
module tb_s_term_loopback_cfg;

   localparam int unsigned W1 = 4;
   localparam int unsigned W2 = 8;
   localparam int unsigned W4 = 16;

   logic          UserCLK = 1'b0;
   logic          UserRST = 1'b1;
   logic [W1-1:0] S1END   = '0;
   logic [W2-1:0] S2MID   = '0;
   logic [W2-1:0] S2END   = '0;
   logic [W4-1:0] S4END   = '0;
   logic [W1-1:0] N1BEG;
   logic [W2-1:0] N2BEG;
   logic [W2-1:0] N2BEGb;
   logic [W4-1:0] N4BEG;
   logic          cfg_shift_en = 1'b0;
   logic          cfg_din      = 1'b0;
   logic          cfg_update   = 1'b0;
   logic          cfg_dout;
`ifdef S_TERM_ACTIVITY_CNT_EN
   logic [15:0]   act_count;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   s_term_loopback_cfg dut (
      .UserCLK(UserCLK), .UserRST(UserRST),
      .S1END(S1END), .S2MID(S2MID), .S2END(S2END), .S4END(S4END),
      .N1BEG(N1BEG), .N2BEG(N2BEG), .N2BEGb(N2BEGb), .N4BEG(N4BEG),
      .cfg_shift_en(cfg_shift_en), .cfg_din(cfg_din), .cfg_update(cfg_update),
      .cfg_dout(cfg_dout)
`ifdef S_TERM_ACTIVITY_CNT_EN
      , .act_count(act_count)
`endif
   );

   always #5 UserCLK = ~UserCLK;

   // ---------------- behavioural model ----------------
   bit          stream[$];          // every config bit shifted in since reset, oldest first
   logic [7:0]  mode_m  = '0;
   logic [15:0] lfsr_m  = 16'hACE1;
   logic [W1-1:0] p1 = '0;
   logic [W2-1:0] p2 = '0, p2b = '0;
   logic [W4-1:0] p4 = '0;
   logic [15:0] cnt_m = '0;

   function automatic bit sr_bit(input int k);
      int idx;
      idx = stream.size() - 8 + k;
      return (idx >= 0) ? stream[idx] : 1'b0;
   endfunction

   function automatic logic [1:0] gmode(input int g);
      return 2'((mode_m >> (2 * g)) & 8'd3);
   endfunction

   function automatic logic [15:0] rev(input logic [15:0] v, input int w);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < w; i++) r = r | (((v >> (w - 1 - i)) & 16'd1) << i);
      return r;
   endfunction

   function automatic logic [15:0] grp_exp(input int w, input logic [15:0] cur,
                                           input logic [15:0] prev, input logic [1:0] m);
      logic [15:0] mask;
      mask = 16'((32'd1 << w) - 32'd1);
      case (m)
         2'b00:   return rev(cur, w);
         2'b01:   return rev(prev, w);
         2'b10:   return lfsr_m & mask;
         default: return 16'h0000;
      endcase
   endfunction

   always @(posedge UserCLK or posedge UserRST) begin
      if (UserRST) begin
         stream.delete();
         mode_m <= '0;
         lfsr_m <= 16'hACE1;
         p1 <= '0; p2 <= '0; p2b <= '0; p4 <= '0;
         cnt_m <= '0;
      end else begin
         logic [7:0] snap;
         bit any_prbs;
         snap = '0;
         for (int k = 0; k < 8; k++) snap = snap | (8'(sr_bit(k)) << k);
         any_prbs = 1'b0;
         for (int g = 0; g < 4; g++) if (gmode(g) == 2'b10) any_prbs = 1'b1;
         if (cfg_update) mode_m <= snap;
         if (cfg_shift_en) stream.push_back(cfg_din);
         if (any_prbs)
            lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
         if (cfg_update) cnt_m <= '0;
         else if ({S1END, S2MID, S2END, S4END} != {p1, p2, p2b, p4} && cnt_m != 16'hFFFF)
            cnt_m <= cnt_m + 16'd1;
         p1 <= S1END; p2 <= S2MID; p2b <= S2END; p4 <= S4END;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: outputs are stable at the falling edge
   always @(negedge UserCLK) begin
      if (chk_en) begin
         chk("n1", 32'(N1BEG),  32'(grp_exp(W1, 16'(S1END), 16'(p1),  gmode(0))));
         chk("n2", 32'(N2BEG),  32'(grp_exp(W2, 16'(S2MID), 16'(p2),  gmode(1))));
         chk("n2b", 32'(N2BEGb), 32'(grp_exp(W2, 16'(S2END), 16'(p2b), gmode(2))));
         chk("n4", 32'(N4BEG),  32'(grp_exp(W4, 16'(S4END), 16'(p4),  gmode(3))));
         chk("cfg_dout", 32'(cfg_dout), 32'(sr_bit(0)));
`ifdef S_TERM_ACTIVITY_CNT_EN
         chk("act_count", 32'(act_count), 32'(cnt_m));
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge UserCLK);
      #1;
   endtask

   task automatic load_cfg(input logic [7:0] v);
      for (int i = 0; i < 8; i++) begin
         cfg_shift_en = 1'b1;
         cfg_din      = v[i];
         step();
      end
      cfg_shift_en = 1'b0;
      cfg_din      = 1'b0;
      cfg_update   = 1'b1;
      step();
      cfg_update   = 1'b0;
   endtask

   initial begin
      step();
      step();
      UserRST = 1'b0;
      chk_en  = 1'b1;
      step();

      // Bypass reflection out of reset
      S4END = 16'h0001;
      S1END = 4'b0011;
      #1;
      chk("lit_n4_bypass", 32'(N4BEG), 32'h8000);
      chk("lit_n1_bypass", 32'(N1BEG), 32'hC);

      // g1 REG: one-cycle latency, others bypass
      S2MID = '0;
      S2END = 8'h03;
      step();
      load_cfg(8'b0000_0100);
      S2MID = 8'h01;
      #1;
      chk("lit_n2_reg_t", 32'(N2BEG), 32'h00);
      chk("lit_n2b_bypass", 32'(N2BEGb), 32'hC0);
      step();
      chk("lit_n2_reg_t1", 32'(N2BEG), 32'h80);

      // g3 PRBS, others TIE0
      load_cfg(8'hBF);
      #1;
      chk("lit_prbs_first", 32'(N4BEG), 32'hACE1);
      chk("lit_tie_n1", 32'(N1BEG), 32'h0);
      chk("lit_tie_n2", 32'(N2BEG), 32'h0);
      chk("lit_tie_n2b", 32'(N2BEGb), 32'h0);
      chk("lit_cfg_dout", 32'(cfg_dout), 32'h1);
      step();
      chk("lit_prbs_second", 32'(N4BEG), 32'h59C3);
      step();
      step();

      // Async reset mid-PRBS
      S4END = 16'h0001;
      S1END = 4'b0011;
      #2;
      UserRST = 1'b1;
      #1;
      chk("lit_rst_n4", 32'(N4BEG), 32'h8000);
      chk("lit_rst_n1", 32'(N1BEG), 32'hC);
      step();
      step();
      UserRST = 1'b0;
      load_cfg(8'h80);
      #1;
      chk("lit_prbs_reseed", 32'(N4BEG), 32'hACE1);

      // Shift and update together: update sees the pre-shift chain
      cfg_shift_en = 1'b1;
      cfg_din      = 1'b1;
      cfg_update   = 1'b1;
      step();
      cfg_shift_en = 1'b0;
      cfg_din      = 1'b0;
      #1;
      chk("lit_same_cycle_old", 32'(N4BEG), 32'h59C3);
      step();
      cfg_update = 1'b0;
      #1;
      chk("lit_tie_after_upd", 32'(N4BEG), 32'h0);

`ifdef S_TERM_ACTIVITY_CNT_EN
      S1END = '0; S2MID = '0; S2END = '0; S4END = '0;
      step();
      cfg_update = 1'b1;
      step();
      cfg_update = 1'b0;
      for (int i = 0; i < 10; i++) begin
         S1END[0] = ~S1END[0];
         step();
      end
      chk("lit_act_10", 32'(act_count), 32'd10);
      cfg_update = 1'b1;
      step();
      cfg_update = 1'b0;
      chk("lit_act_clr", 32'(act_count), 32'd0);
`endif

      // Random traffic, config and occasional resets
      for (int n = 0; n < 3000; n++) begin
         S1END        = W1'($urandom);
         S2MID        = W2'($urandom);
         S2END        = W2'($urandom);
         S4END        = W4'($urandom);
         cfg_shift_en = ($urandom_range(0, 2) == 0);
         cfg_din      = 1'($urandom);
         cfg_update   = ($urandom_range(0, 11) == 0);
         UserRST      = ($urandom_range(0, 249) == 0);
         step();
      end
      UserRST = 1'b0;
      step();
      step();

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
